// File: rtl/neuraedge_noc_pkg.sv
// Shared flit-type encoding, field offsets, bridge state enums and flit decode helpers.
// Latency: none (types and pure functions only).
// Backpressure: none.
package neuraedge_noc_pkg;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ING_IDLE,
    ING_LOCK
  } ing_state_e;

  typedef enum logic [1:0] {
    E_IDLE,
    E_FWD,
    E_DROP
  } egr_state_e;

  // Type field is flit[FLIT_W-1 -: 2]; channel ID starts at flit[FLIT_W-3].
  localparam int FT_LSB_OFS    = 2;
  localparam int CH_ID_MSB_OFS = 3;
  localparam int CH_ID_MAX_W   = 4;

  function automatic logic is_head(input logic [1:0] ft);
    return (ft == FT_HEAD) || (ft == FT_SINGLE);
  endfunction

  function automatic logic is_tail(input logic [1:0] ft);
    return (ft == FT_TAIL) || (ft == FT_SINGLE);
  endfunction

  // id_nib is the widest possible ID field; the real ID occupies its top id_w bits.
  function automatic logic [CH_ID_MAX_W-1:0] flit_ch_id(input logic [CH_ID_MAX_W-1:0] id_nib,
                                                        input int unsigned id_w);
    return id_nib >> (CH_ID_MAX_W - id_w);
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous flit FIFO with a DEPTH+1-range occupancy count.
// Latency: a pushed word is visible on dout the cycle after the push edge.
// Backpressure: full blocks push, empty blocks pop; simultaneous push/pop allowed.
module noc_flit_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_en;
  logic             pop_en;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/neuraedge_host_bridge.sv
// Multi-channel host<->mesh bridge: packet-atomic round-robin ingress, channel-ID demuxed egress.
// Latency: ingress 2 cycles from push into an idle empty FIFO; egress 1 cycle through the output register.
// Backpressure: ingress ready = FIFO not full; egress ready follows the destination's host_ready_in.
module neuraedge_host_bridge
  import neuraedge_noc_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int FLIT_W     = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*FLIT_W-1:0] host_flit_in,
  input  logic [NUM_CH-1:0]        host_valid_in,
  output logic [NUM_CH-1:0]        host_ready_out,
  output logic [FLIT_W-1:0]        mesh_flit_out,
  output logic                     mesh_valid_out,
  input  logic                     mesh_ready_in,
  input  logic [FLIT_W-1:0]        mesh_flit_in,
  input  logic                     mesh_valid_in,
  output logic                     mesh_ready_out,
  output logic [FLIT_W-1:0]        host_flit_out,
  output logic [NUM_CH-1:0]        host_valid_out,
  input  logic [NUM_CH-1:0]        host_ready_in,
  input  logic                     err_clr,
  output logic [15:0]              err_cnt,
  output logic                     irq_err
);
  localparam int CH_ID_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]  fifo_full;
  logic [NUM_CH-1:0]  fifo_empty;
  logic [NUM_CH-1:0]  fifo_push;
  logic [NUM_CH-1:0]  fifo_pop;
  logic [FLIT_W-1:0]  fifo_dout [NUM_CH];
  logic               mesh_xfer;
  ing_state_e         ing_state, ing_next;
  logic [CH_ID_W-1:0] grant, grant_next;
  logic [CH_ID_W-1:0] last_grant, last_grant_next;
  logic [CH_ID_W-1:0] rr_idx, rr_sel;
  logic               rr_vld;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign fifo_push[i] = host_valid_in[i] && !fifo_full[i] && !rst;
    assign fifo_pop[i]  = mesh_xfer && (grant == CH_ID_W'(i));
    noc_flit_fifo #(.WIDTH(FLIT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push[i]),
      .din   (host_flit_in[i*FLIT_W +: FLIT_W]),
      .pop   (fifo_pop[i]),
      .dout  (fifo_dout[i]),
      .full  (fifo_full[i]),
      .empty (fifo_empty[i])
    );
  end

  assign host_ready_out = rst ? '0 : ~fifo_full;
  assign mesh_valid_out = !rst && (ing_state == ING_LOCK) && !fifo_empty[grant];
  assign mesh_flit_out  = fifo_dout[grant];
  assign mesh_xfer      = mesh_valid_out && mesh_ready_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      ing_state  <= ING_IDLE;
      grant      <= '0;
      last_grant <= CH_ID_W'(NUM_CH - 1);
    end else begin
      ing_state  <= ing_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
    end
  end

  always_comb begin
    ing_next        = ing_state;
    grant_next      = grant;
    last_grant_next = last_grant;
    rr_vld          = 1'b0;
    rr_sel          = '0;
    rr_idx          = '0;
    // Scan farthest-first so the nearest non-empty channel after last_grant wins.
    for (int k = NUM_CH; k >= 1; k--) begin
      rr_idx = CH_ID_W'((int'(last_grant) + k) % NUM_CH);
      if (!fifo_empty[rr_idx]) begin
        rr_vld = 1'b1;
        rr_sel = rr_idx;
      end
    end
    case (ing_state)
      ING_IDLE: begin
        if (rr_vld) begin
          grant_next = rr_sel;
          ing_next   = ING_LOCK;
        end
      end
      ING_LOCK: begin
        if (mesh_xfer && is_tail(mesh_flit_out[FLIT_W-FT_LSB_OFS +: 2])) begin
          ing_next        = ING_IDLE;
          last_grant_next = grant;
        end
      end
      default: ing_next = ING_IDLE;
    endcase
  end

  egr_state_e             e_state, e_next;
  logic [CH_ID_W-1:0]     dest;
  logic                   out_v;
  logic [FLIT_W-1:0]      out_flit;
  logic [1:0]             in_ft;
  logic [CH_ID_MAX_W-1:0] in_id;
  logic                   id_ok;
  logic                   mesh_acc;
  logic                   fwd;
  logic                   drop;
  logic                   latch_dest;

  assign in_ft          = mesh_flit_in[FLIT_W-FT_LSB_OFS +: 2];
  assign in_id          = flit_ch_id(mesh_flit_in[FLIT_W-CH_ID_MSB_OFS -: CH_ID_MAX_W], CH_ID_W);
  assign id_ok          = int'(in_id) < NUM_CH;
  assign mesh_ready_out = rst ? 1'b0 :
                          (e_state == E_DROP) ? 1'b1 : (!out_v || host_ready_in[dest]);
  assign mesh_acc       = mesh_valid_in && mesh_ready_out;
  assign host_valid_out = (out_v && !rst) ? (NUM_CH'(1) << dest) : '0;
  assign host_flit_out  = out_flit;

  always_comb begin
    e_next     = e_state;
    fwd        = 1'b0;
    drop       = 1'b0;
    latch_dest = 1'b0;
    if (mesh_acc) begin
      case (e_state)
        E_IDLE: begin
          if (is_head(in_ft) && id_ok) begin
            fwd        = 1'b1;
            latch_dest = 1'b1;
            if (!is_tail(in_ft)) e_next = E_FWD;
          end else begin
            // Bad-ID heads and orphan BODY/TAIL flits each count as one dropped packet.
            drop = 1'b1;
            if (is_head(in_ft) && !is_tail(in_ft)) e_next = E_DROP;
          end
        end
        E_FWD: begin
          fwd = 1'b1;
          if (is_tail(in_ft)) e_next = E_IDLE;
        end
        E_DROP: begin
          if (is_tail(in_ft)) e_next = E_IDLE;
        end
        default: e_next = E_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_state <= E_IDLE;
      out_v   <= 1'b0;
      dest    <= '0;
    end else begin
      e_state <= e_next;
      if (fwd)                                out_v <= 1'b1;
      else if (out_v && host_ready_in[dest])  out_v <= 1'b0;
      if (latch_dest) dest <= in_id[CH_ID_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (fwd) out_flit <= mesh_flit_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
      irq_err <= 1'b0;
    end else if (err_clr) begin
      err_cnt <= drop ? 16'd1 : 16'd0;
      irq_err <= drop;
    end else if (drop) begin
      if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      irq_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_neuraedge_host_bridge.sv
// Directed bench for neuraedge_host_bridge: a 4-channel instance for arbitration, egress
// and reset, plus a 3-channel instance for out-of-range channel IDs.
module tb_neuraedge_host_bridge;
  localparam int FW = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4*FW-1:0] host_flit_in;
  logic [3:0]      host_valid_in, host_ready_out, host_valid_out, host_ready_in;
  logic [FW-1:0]   mesh_flit_out, mesh_flit_in, host_flit_out;
  logic            mesh_valid_out, mesh_ready_in, mesh_valid_in, mesh_ready_out;
  logic            err_clr, irq_err;
  logic [15:0]     err_cnt;

  logic [3*FW-1:0] d3_host_flit_in;
  logic [2:0]      d3_host_valid_in, d3_host_ready_out, d3_host_valid_out, d3_host_ready_in;
  logic [FW-1:0]   d3_mesh_flit_out, d3_mesh_flit_in, d3_host_flit_out;
  logic            d3_mesh_valid_out, d3_mesh_ready_in, d3_mesh_valid_in, d3_mesh_ready_out;
  logic            d3_err_clr, d3_irq_err;
  logic [15:0]     d3_err_cnt;

  neuraedge_host_bridge #(.NUM_CH(4), .FLIT_W(FW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .host_flit_in(host_flit_in), .host_valid_in(host_valid_in), .host_ready_out(host_ready_out),
    .mesh_flit_out(mesh_flit_out), .mesh_valid_out(mesh_valid_out), .mesh_ready_in(mesh_ready_in),
    .mesh_flit_in(mesh_flit_in), .mesh_valid_in(mesh_valid_in), .mesh_ready_out(mesh_ready_out),
    .host_flit_out(host_flit_out), .host_valid_out(host_valid_out), .host_ready_in(host_ready_in),
    .err_clr(err_clr), .err_cnt(err_cnt), .irq_err(irq_err)
  );

  neuraedge_host_bridge #(.NUM_CH(3), .FLIT_W(FW), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .rst(rst),
    .host_flit_in(d3_host_flit_in), .host_valid_in(d3_host_valid_in), .host_ready_out(d3_host_ready_out),
    .mesh_flit_out(d3_mesh_flit_out), .mesh_valid_out(d3_mesh_valid_out), .mesh_ready_in(d3_mesh_ready_in),
    .mesh_flit_in(d3_mesh_flit_in), .mesh_valid_in(d3_mesh_valid_in), .mesh_ready_out(d3_mesh_ready_out),
    .host_flit_out(d3_host_flit_out), .host_valid_out(d3_host_valid_out), .host_ready_in(d3_host_ready_in),
    .err_clr(d3_err_clr), .err_cnt(d3_err_cnt), .irq_err(d3_irq_err)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [FW-1:0] mq_flit [$];
  int            mq_cyc  [$];
  logic [FW-1:0] hq_flit [$];
  logic [3:0]    hq_ch   [$];
  int            hq_cyc  [$];
  int            d3_vld_cnt = 0;

  // Record completed transfers mid-cycle, where every handshake signal is stable.
  always @(negedge clk) begin
    if (mesh_valid_out && mesh_ready_in) begin
      mq_flit.push_back(mesh_flit_out);
      mq_cyc.push_back(cyc);
    end
    if ((host_valid_out & host_ready_in) != 4'b0) begin
      hq_flit.push_back(host_flit_out);
      hq_ch.push_back(host_valid_out);
      hq_cyc.push_back(cyc);
    end
    if (d3_host_valid_out != 3'b0) d3_vld_cnt = d3_vld_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_push(input int ch, input logic [FW-1:0] f);
    host_flit_in[ch*FW +: FW] = f;
    host_valid_in[ch] = 1'b1;
    step();
    host_valid_in[ch] = 1'b0;
  endtask

  task automatic mesh_send(input bit to3, input logic [FW-1:0] f, output bit ok);
    ok = 1'b0;
    if (to3) begin d3_mesh_flit_in = f; d3_mesh_valid_in = 1'b1; end
    else     begin mesh_flit_in    = f; mesh_valid_in    = 1'b1; end
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = to3 ? d3_mesh_ready_out : mesh_ready_out;
      @(posedge clk);
      #1;
    end
    d3_mesh_valid_in = 1'b0;
    mesh_valid_in    = 1'b0;
  endtask

  task automatic wait_mq(input int n, input string tag);
    for (int k = 0; k < 100 && mq_flit.size() < n; k++) step();
    chk(tag, 64'(mq_flit.size()), 64'(n));
  endtask

  task automatic wait_hq(input int n, input string tag);
    for (int k = 0; k < 100 && hq_flit.size() < n; k++) step();
    chk(tag, 64'(hq_flit.size()), 64'(n));
  endtask

  logic [FW-1:0] t5 [5];
  int  base, hbase, d3base, send_fail;
  bit  ok, gap_bad, stall_bad;

  initial begin
    t5[0] = 64'h5000_0000_0000_0001;
    t5[1] = 64'h0000_0000_0000_0002;
    t5[2] = 64'h0000_0000_0000_0003;
    t5[3] = 64'h0000_0000_0000_0004;
    t5[4] = 64'h8000_0000_0000_0005;
    rst = 1'b1;
    host_flit_in = '0; host_valid_in = '0; mesh_ready_in = 1'b1;
    mesh_flit_in = '0; mesh_valid_in = 1'b0; host_ready_in = 4'hF; err_clr = 1'b0;
    d3_host_flit_in = '0; d3_host_valid_in = '0; d3_mesh_ready_in = 1'b1;
    d3_mesh_flit_in = '0; d3_mesh_valid_in = 1'b0; d3_host_ready_in = 3'b111; d3_err_clr = 1'b0;
    send_fail = 0;

    repeat (3) step();
    chk("rst_host_rdy", 64'(host_ready_out), 64'd0);
    chk("rst_mesh_rdy", 64'(mesh_ready_out), 64'd0);
    chk("rst_mesh_vld", 64'(mesh_valid_out), 64'd0);
    chk("rst_host_vld", 64'(host_valid_out), 64'd0);
    rst = 1'b0;
    step();
    chk("init_host_rdy", 64'(host_ready_out), 64'hF);
    chk("init_mesh_rdy", 64'(mesh_ready_out), 64'd1);
    chk("init_err", 64'({irq_err, err_cnt}), 64'd0);
    chk("init_d3_rdy", 64'(d3_host_ready_out), 64'h7);
    chk("init_d3_vld", 64'(d3_mesh_valid_out), 64'd0);

    // T1: single flit on ch2, latency 2 from the push cycle
    host_flit_in[2*FW +: FW] = 64'h4000_0000_0000_00AA;
    host_valid_in = 4'b0100;
    step();
    host_valid_in = '0;
    chk("t1_vld_c1", 64'(mesh_valid_out), 64'd0);
    step();
    chk("t1_vld_c2", 64'(mesh_valid_out), 64'd1);
    chk("t1_flit", mesh_flit_out, 64'h4000_0000_0000_00AA);
    step();
    chk("t1_locked_idle", 64'(mesh_valid_out), 64'd0);
    host_push(2, 64'h8000_0000_0000_00AB);
    chk("t1_tail_vld", 64'(mesh_valid_out), 64'd1);
    chk("t1_tail_flit", mesh_flit_out, 64'h8000_0000_0000_00AB);
    step();

    // T2: ch0 three-flit packet and ch1 single pushed together
    base = mq_flit.size();
    host_flit_in[0 +: FW]  = 64'h4000_0000_0000_0010;
    host_flit_in[FW +: FW] = 64'hC000_0000_0000_0020;
    host_valid_in = 4'b0011;
    step();
    host_flit_in[0 +: FW] = 64'h0000_0000_0000_0011;
    host_valid_in = 4'b0001;
    step();
    host_flit_in[0 +: FW] = 64'h8000_0000_0000_0012;
    step();
    host_valid_in = '0;
    wait_mq(base + 4, "t2_count");
    chk("t2_f0", mq_flit[base],   64'h4000_0000_0000_0010);
    chk("t2_f1", mq_flit[base+1], 64'h0000_0000_0000_0011);
    chk("t2_f2", mq_flit[base+2], 64'h8000_0000_0000_0012);
    chk("t2_f3", mq_flit[base+3], 64'hC000_0000_0000_0020);
    chk("t2_contig", 64'(mq_cyc[base+2] - mq_cyc[base]), 64'd2);
    chk("t2_bubble", 64'(mq_cyc[base+3] - mq_cyc[base+2]), 64'd2);

    // T3: ch0 stalls mid-packet while ch3 waits with a single
    base = mq_flit.size();
    host_flit_in[0 +: FW] = 64'h4000_0000_0000_0030;
    host_valid_in = 4'b0001;
    step();
    host_flit_in[3*FW +: FW] = 64'hC000_0000_0000_0033;
    host_valid_in = 4'b1000;
    step();
    host_valid_in = '0;
    chk("t3_head", mesh_flit_out, 64'h4000_0000_0000_0030);
    step();
    gap_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (mesh_valid_out) gap_bad = 1'b1;
      step();
    end
    chk("t3_withheld", 64'(gap_bad), 64'd0);
    host_push(0, 64'h8000_0000_0000_0031);
    wait_mq(base + 3, "t3_count");
    chk("t3_f0", mq_flit[base],   64'h4000_0000_0000_0030);
    chk("t3_f1", mq_flit[base+1], 64'h8000_0000_0000_0031);
    chk("t3_f2", mq_flit[base+2], 64'hC000_0000_0000_0033);

    // Orphan BODY in E_IDLE is dropped and counted; err_clr interactions
    hbase = hq_flit.size();
    mesh_send(1'b0, 64'h0000_0000_0000_0055, ok);
    chk("orph_acc", 64'(ok), 64'd1);
    chk("orph_cnt", 64'(err_cnt), 64'd1);
    chk("orph_irq", 64'(irq_err), 64'd1);
    step();
    step();
    chk("orph_nofwd", 64'(hq_flit.size()), 64'(hbase));
    err_clr = 1'b1;
    mesh_send(1'b0, 64'h8000_0000_0000_0056, ok);
    err_clr = 1'b0;
    chk("clr_drop_cnt", 64'(err_cnt), 64'd1);
    chk("clr_drop_irq", 64'(irq_err), 64'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_cnt", 64'(err_cnt), 64'd0);
    chk("clr_irq", 64'(irq_err), 64'd0);

    // T5: egress to ch1 with ch1 not ready for 4 cycles
    hbase = hq_flit.size();
    host_ready_in = 4'b1101;
    stall_bad = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          mesh_send(1'b0, t5[i], ok);
          if (!ok) send_fail++;
        end
      end
      begin
        repeat (3) begin
          step();
          if (mesh_ready_out || host_valid_out != 4'b0010 || host_flit_out != t5[0]) stall_bad = 1'b1;
        end
        step();
        host_ready_in = 4'hF;
      end
    join
    chk("t5_stall", 64'(stall_bad), 64'd0);
    chk("t5_sends", 64'(send_fail), 64'd0);
    wait_hq(hbase + 5, "t5_count");
    for (int i = 0; i < 5; i++) begin
      chk("t5_flit", hq_flit[hbase+i], t5[i]);
      chk("t5_ch", 64'(hq_ch[hbase+i]), 64'h2);
    end
    chk("t5_thruput", 64'(hq_cyc[hbase+4] - hq_cyc[hbase+1]), 64'd3);

    // T4: NUM_CH=3 instance, HEAD with ID 3 plus BODY and TAIL are dropped as one packet
    d3base = d3_vld_cnt;
    send_fail = 0;
    mesh_send(1'b1, 64'h7000_0000_0000_0001, ok); if (!ok) send_fail++;
    mesh_send(1'b1, 64'h0000_0000_0000_0002, ok); if (!ok) send_fail++;
    mesh_send(1'b1, 64'h8000_0000_0000_0003, ok); if (!ok) send_fail++;
    step();
    step();
    chk("t4_sends", 64'(send_fail), 64'd0);
    chk("t4_no_vld", 64'(d3_vld_cnt), 64'(d3base));
    chk("t4_cnt", 64'(d3_err_cnt), 64'd1);
    chk("t4_irq", 64'(d3_irq_err), 64'd1);
    mesh_send(1'b1, 64'hE000_0000_0000_0009, ok);
    chk("t4_id2_vld", 64'(d3_host_valid_out), 64'h4);
    chk("t4_id2_flit", d3_host_flit_out, 64'hE000_0000_0000_0009);

    // T6: reset with partial packets held on both paths
    host_ready_in = 4'b1011;
    mesh_send(1'b0, 64'h0000_0000_0000_0060, ok);
    mesh_send(1'b0, 64'h6000_0000_0000_0061, ok);
    mesh_ready_in = 1'b0;
    host_push(1, 64'h4000_0000_0000_0070);
    host_push(1, 64'h0000_0000_0000_0071);
    chk("t6_pre_cnt", 64'(err_cnt), 64'd1);
    chk("t6_pre_hvld", 64'(host_valid_out), 64'h4);
    rst = 1'b1;
    #1;
    chk("t6_rst_outs", 64'({host_ready_out, mesh_ready_out, mesh_valid_out, host_valid_out}), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("t6_mesh_vld", 64'(mesh_valid_out), 64'd0);
    chk("t6_host_vld", 64'(host_valid_out), 64'd0);
    chk("t6_err", 64'({irq_err, err_cnt}), 64'd0);
    chk("t6_host_rdy", 64'(host_ready_out), 64'hF);
    mesh_ready_in = 1'b1;
    host_ready_in = 4'hF;
    base = mq_flit.size();
    repeat (3) step();
    chk("t6_fifo_empty", 64'(mq_flit.size()), 64'(base));
    mesh_send(1'b0, 64'hC000_0000_0000_0080, ok);
    chk("t6_eg_vld", 64'(host_valid_out), 64'h1);
    chk("t6_eg_flit", host_flit_out, 64'hC000_0000_0000_0080);
    host_push(1, 64'hC000_0000_0000_0081);
    wait_mq(base + 1, "t6_in_count");
    chk("t6_in_flit", mq_flit[base], 64'hC000_0000_0000_0081);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
